reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 65 ++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file (x0 hardwired to zero) with a per-register busy scoreboard.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data to the matching read ports.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NREAD-1:0][4:0]         raddr,
  output logic [NREAD-1:0][XLEN-1:0]    rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic [NWRITE-1:0]             wr_en,
  input  logic [NWRITE-1:0][4:0]        wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]   wr_data,
  input  logic                          claim_en,
  input  logic [4:0]                    claim_rd,
  output logic                          claim_ready
);

  logic [XLEN-1:0] regs [32];
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;

  // busy[0] is never set, so a claim of x0 is always accepted and x0 never reads busy.
  assign claim_ready = claim_en & ((claim_rd == '0) | ~busy[claim_rd]);

  // Writes clear busy first so a same-edge accepted claim of the same register leaves it set.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && wr_addr[j] != '0) busy_nxt[wr_addr[j]] = 1'b0;
    end
    if (claim_ready && claim_rd != '0) busy_nxt[claim_rd] = 1'b1;
  end

  // Later ports are assigned last, so the highest-numbered write port wins a collision.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && wr_addr[j] != '0) regs[wr_addr[j]] <= wr_data[j];
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdata[i] = (raddr[i] == '0) ? '0 : regs[raddr[i]];
      rbusy[i] = busy[raddr[i]];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && raddr[i] != '0 && wr_addr[j] == raddr[i]) begin
          rdata[i] = wr_data[j];
          rbusy[i] = 1'b0;
        end
      end
`endif
    end
  end

endmodule
